prio_req_queue: RTL and testbench
=================================

PRIO_REQ_QUEUE -- requirements
Module: prio_req_queue

Interface
REQ-001 Parameter HOLD_CYC, default 2, meaning: idle gap in cycles after each completed service handshake (0 allowed).
REQ-002 The module SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_pulse  input  [4:1]  one-cycle request pulses; bit i requests service for source i.
REQ-006 svc_ready  input  1  downstream accepts the current grant.
REQ-007 ovf_clr  input  1  clears all overflow flags.
REQ-008 r  output  [4:1]  registered pending-request vector, fed to the priority encoder stage.
REQ-009 svc_valid  output  1  grant offered to downstream.
REQ-010 svc_id  output  [2:0]  granted source code: 3'b100..3'b001 for sources 4..1, 3'b000 = none.
REQ-011 ovf  output  [4:1]  sticky per-source overflow flags.

Function
REQ-012 Pending bit r[i] SHALL set on the clock edge after req_pulse[i]=1 (1-cycle latency).
REQ-013 Priority SHALL be fixed: source 4 highest, source 1 lowest; encoding per REQ-010.
REQ-014 FSM states SHALL be IDLE, GRANT, HOLD.
REQ-015 IDLE: if r != 0, register the encoded highest pending id into svc_id and go to GRANT; otherwise stay.
REQ-016 GRANT: svc_valid=1; svc_id SHALL stay stable until handshake; no preemption by higher-priority arrivals.
REQ-017 Handshake = svc_valid & svc_ready; on that edge clear r[svc_id], then go to HOLD (HOLD_CYC>0) or IDLE (HOLD_CYC=0).
REQ-018 HOLD: down-counter loaded with HOLD_CYC-1 on entry; return to IDLE when it reaches 0; svc_valid=0 throughout.
REQ-019 Latency: pulse at edge t -> r set at t+1 -> svc_valid=1 at t+2 when FSM was IDLE.
REQ-020 svc_valid SHALL be 0 in IDLE and HOLD; svc_id SHALL read 3'b000 whenever svc_valid=0.
REQ-021 A req_pulse[i] while r[i]=1 and r[i] is not being cleared that edge: r[i] stays 1 and ovf[i] sets.
REQ-022 A req_pulse[i] on the handshake edge clearing r[i]: r[i] stays 1, ovf[i] unchanged (counted as new request).
REQ-023 ovf bits SHALL hold until ovf_clr=1 or reset; if ovf_clr and a new overflow coincide, the overflow wins (bit stays set).
REQ-024 svc_ready while svc_valid=0 SHALL be ignored.
REQ-025 The HOLD counter SHALL be wide enough for HOLD_CYC; no wrap-around permitted.

Reset
REQ-026 reset SHALL force r=0, ovf=0, svc_valid=0, svc_id=3'b000, counter=0, state IDLE on the next edge.
REQ-027 reset mid-GRANT or mid-HOLD SHALL abandon the grant without a handshake; req_pulse during reset is dropped.

Structure
REQ-028 State encodings and the 3-bit id constants SHALL reside in a shared package reused by the encoder stage and its consumers.
REQ-029 The id computation SHALL instantiate the existing 4-bit priority encoder prio_encoder_casez as the single sub-module, driven from r.
REQ-030 All outputs SHALL be registered; no combinational path from req_pulse or svc_ready to any output.

Verification
REQ-031 req_pulse=4'b0010 at edge 0, svc_ready=1 -> r=4'b0010 at edge 1, svc_valid=1 & svc_id=3'b010 at edge 2, r=0 at edge 3, svc_valid=0 during edges 3-4 (HOLD_CYC=2).
REQ-032 req_pulse=4'b0101 together, svc_ready=1 -> grant id 3'b011 first, then id 3'b001 after HOLD; r ends 0.
REQ-033 svc_ready=0, id 3'b001 granted, then req_pulse=4'b1000 -> svc_id stays 3'b001 until svc_ready=1; next grant 3'b100.
REQ-034 r[2]=1 pending, req_pulse[2]=1 again -> ovf=4'b0010; ovf_clr=1 -> ovf=0; pulse coinciding with clear handshake -> r[2]=1, ovf=0.
REQ-035 reset asserted during GRANT with r=4'b1100 -> next edge r=0, svc_valid=0, svc_id=0, state IDLE.
REQ-036 HOLD_CYC=0, r=4'b0011, svc_ready=1 -> back-to-back grants 3'b010 and 3'b001 separated by one IDLE cycle.

Source files
------------

// File: rtl/prio_req_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prio_req_queue_pkg
// Brief    : FSM states, 3-bit source id codes and id-to-mask helper.
// Revision : 1.0
// ============================================================================
package prio_req_queue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [2:0] c_id_none = 3'b000;
    localparam logic [2:0] c_id_src1 = 3'b001;
    localparam logic [2:0] c_id_src2 = 3'b010;
    localparam logic [2:0] c_id_src3 = 3'b011;
    localparam logic [2:0] c_id_src4 = 3'b100;

    // Pending-vector bit owned by a given source id; none maps to no bit.
    function automatic logic [4:1] id_to_mask(input logic [2:0] id);
        logic [4:1] mask;
        mask = '0;
        case (id)
            c_id_src1: mask = 4'b0001;
            c_id_src2: mask = 4'b0010;
            c_id_src3: mask = 4'b0100;
            c_id_src4: mask = 4'b1000;
            default:   mask = '0;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prio_encoder_casez.sv
`default_nettype none
// ============================================================================
// Module   : prio_encoder_casez
// Brief    : Fixed-priority 4-bit encoder, bit 3 (source 4) highest.
// Revision : 1.0
// ============================================================================
module prio_encoder_casez
    import prio_req_queue_pkg::*;
(
    input  logic [3:0] req,
    output logic [2:0] id
);

    always_comb begin
        id = c_id_none;
        casez (req)
            4'b1???: id = c_id_src4;
            4'b01??: id = c_id_src3;
            4'b001?: id = c_id_src2;
            4'b0001: id = c_id_src1;
            default: id = c_id_none;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/prio_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : prio_req_queue
// Brief    : Pulse-to-pending request queue with fixed-priority grant FSM.
// Revision : 1.0
// ============================================================================
module prio_req_queue
    import prio_req_queue_pkg::*;
#(
    parameter int HOLD_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:1] req_pulse,
    input  logic       svc_ready,
    input  logic       ovf_clr,
    output logic [4:1] r,
    output logic       svc_valid,
    output logic [2:0] svc_id,
    output logic [4:1] ovf
);

    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] c_hold_load = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_valid_nxt;
    logic [2:0]       w_id_nxt;
    logic [2:0]       w_enc_id;
    logic             w_hs;
    logic [4:1]       w_clr;
    logic [4:1]       w_ovf_set;

    prio_encoder_casez u_enc (
        .req (r),
        .id  (w_enc_id)
    );

    assign w_hs      = svc_valid & svc_ready;
    assign w_clr     = w_hs ? id_to_mask(svc_id) : 4'b0000;
    // A pulse landing on the bit being cleared is a fresh request, not an overflow.
    assign w_ovf_set = req_pulse & r & ~w_clr;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = svc_valid;
        w_id_nxt    = svc_id;
        case (r_state)
            IDLE: begin
                if (r != 4'b0000) begin
                    w_state_nxt = GRANT;
                    w_valid_nxt = 1'b1;
                    w_id_nxt    = w_enc_id;
                end
            end
            GRANT: begin
                if (svc_ready) begin
                    w_valid_nxt = 1'b0;
                    w_id_nxt    = c_id_none;
                    if (HOLD_CYC > 0) begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = c_hold_load;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
                w_id_nxt    = c_id_none;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r         <= '0;
            ovf       <= '0;
            svc_valid <= 1'b0;
            svc_id    <= c_id_none;
            r_cnt     <= '0;
            r_state   <= IDLE;
        end else begin
            r         <= (r & ~w_clr) | req_pulse;
            ovf       <= (ovf & {4{~ovf_clr}}) | w_ovf_set;
            svc_valid <= w_valid_nxt;
            svc_id    <= w_id_nxt;
            r_cnt     <= w_cnt_nxt;
            r_state   <= w_state_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prio_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_req_queue
// Brief    : Vector table, directed sequences and random traffic vs. model.
// Revision : 1.0
// ============================================================================
module tb_prio_req_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:1] req_pulse;
    logic       svc_ready;
    logic       ovf_clr;

    logic [4:1] a_r, b_r, a_ovf, b_ovf;
    logic       a_valid, b_valid;
    logic [2:0] a_id, b_id;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    prio_req_queue #(.HOLD_CYC(2)) dut_a (
        .clk(clk), .reset(reset), .req_pulse(req_pulse), .svc_ready(svc_ready),
        .ovf_clr(ovf_clr), .r(a_r), .svc_valid(a_valid), .svc_id(a_id), .ovf(a_ovf)
    );

    prio_req_queue #(.HOLD_CYC(0)) dut_b (
        .clk(clk), .reset(reset), .req_pulse(req_pulse), .svc_ready(svc_ready),
        .ovf_clr(ovf_clr), .r(b_r), .svc_valid(b_valid), .svc_id(b_id), .ovf(b_ovf)
    );

    // Reference model: pending set, current grant, and a quiet-time budget
    // that must drain after a handshake before a new grant may be taken.
    int         hold_of [2] = '{2, 0};
    logic [4:1] m_pend  [2];
    int         m_gid   [2];
    int         m_quiet [2];
    logic [4:1] m_ovf   [2];

    function automatic int highest(input logic [4:1] v);
        for (int i = 4; i >= 1; i--) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_edge(input int k);
        logic [4:1] old, cleared;
        bit hs;
        if (reset) begin
            m_pend[k] = '0; m_gid[k] = 0; m_quiet[k] = 0; m_ovf[k] = '0;
        end else begin
            old     = m_pend[k];
            cleared = '0;
            hs      = (m_gid[k] != 0) && svc_ready;
            if (hs) cleared[m_gid[k]] = 1'b1;
            m_ovf[k] = (ovf_clr ? 4'b0000 : m_ovf[k]) | (req_pulse & old & ~cleared);
            if (m_gid[k] != 0) begin
                if (hs) begin
                    m_gid[k]   = 0;
                    m_quiet[k] = hold_of[k];
                end
            end else if (m_quiet[k] > 0) begin
                m_quiet[k]--;
            end else begin
                m_gid[k] = highest(old);
            end
            m_pend[k] = (old & ~cleared) | req_pulse;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk("model_a", {a_r, a_valid, 1'b0, a_id, a_ovf},
            {m_pend[0], (m_gid[0] != 0), 1'b0, 3'(m_gid[0]), m_ovf[0]});
        chk("model_b", {b_r, b_valid, 1'b0, b_id, b_ovf},
            {m_pend[1], (m_gid[1] != 0), 1'b0, 3'(m_gid[1]), m_ovf[1]});
    endtask

    task automatic do_reset();
        reset = 1'b1; req_pulse = '0; svc_ready = 1'b0; ovf_clr = 1'b0;
        step();
        reset = 1'b0;
        chk("rst_a", {a_r, a_valid, a_id, a_ovf}, 12'h000);
        chk("rst_b", {b_r, b_valid, b_id, b_ovf}, 12'h000);
    endtask

    task automatic expect_a(input string name, input logic [4:1] er, input logic ev,
                            input logic [2:0] eid);
        chk({name, "_r"},  32'(a_r), 32'(er));
        chk({name, "_v"},  32'(a_valid), 32'(ev));
        chk({name, "_id"}, 32'(a_id), 32'(eid));
    endtask

    typedef struct {
        logic [4:1] pulse;
        logic       ready;
        logic       clr;
        logic [4:1] er;
        logic       ev;
        logic [2:0] eid;
        logic [4:1] eovf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset = 1'b1; req_pulse = '0; svc_ready = 1'b0; ovf_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0; m_gid[k] = 0; m_quiet[k] = 0; m_ovf[k] = '0;
        end

        //                pulse   rdy  clr  exp r   v     id      ovf
        tbl.push_back('{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 3'b010, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0101, 1'b1, 1'b0, 4'b0101, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0101, 1'b1, 3'b011, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0001, 1'b1, 3'b001, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 3'b000, 4'b0000});
        // overflow set, cleared, then a pulse on the clearing handshake
        tbl.push_back('{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 3'b010, 4'b0000});
        tbl.push_back('{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 3'b010, 4'b0010});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1, 3'b010, 4'b0000});
        tbl.push_back('{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 3'b000, 4'b0000});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 3'b010, 4'b0000});
        // overflow coinciding with clear: overflow wins
        tbl.push_back('{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 3'b010, 4'b0010});
        tbl.push_back('{4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 3'b010, 4'b0010});
        tbl.push_back('{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 3'b000, 4'b0000});

        do_reset();
        foreach (tbl[i]) begin
            req_pulse = tbl[i].pulse; svc_ready = tbl[i].ready; ovf_clr = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d", i), {a_r, a_valid, 1'b0, a_id, a_ovf},
                {tbl[i].er, tbl[i].ev, 1'b0, tbl[i].eid, tbl[i].eovf});
        end

        // No preemption while downstream stalls; higher source served next.
        do_reset();
        req_pulse = 4'b0001; step();
        req_pulse = 4'b0000; step();
        expect_a("stall_g1", 4'b0001, 1'b1, 3'b001);
        req_pulse = 4'b1000; step();
        req_pulse = 4'b0000; step(); step();
        expect_a("stall_hold", 4'b1001, 1'b1, 3'b001);
        svc_ready = 1'b1; step();
        expect_a("stall_hs", 4'b1000, 1'b0, 3'b000);
        svc_ready = 1'b0; step(); step(); step();
        expect_a("stall_g4", 4'b1000, 1'b1, 3'b100);

        // Reset in the middle of a grant drops the grant and concurrent pulses.
        do_reset();
        req_pulse = 4'b1100; step();
        req_pulse = 4'b0000; step();
        expect_a("pre_rst", 4'b1100, 1'b1, 3'b100);
        reset = 1'b1; req_pulse = 4'b0011; step();
        expect_a("mid_rst", 4'b0000, 1'b0, 3'b000);
        reset = 1'b0; req_pulse = 4'b0000; step();
        expect_a("post_rst", 4'b0000, 1'b0, 3'b000);

        // Zero hold: back-to-back grants with a single idle cycle between.
        do_reset();
        svc_ready = 1'b1; req_pulse = 4'b0011; step();
        req_pulse = 4'b0000;
        chk("h0_r", 32'({b_r, b_valid}), 32'({4'b0011, 1'b0}));
        step();
        chk("h0_g2", 32'({b_valid, b_id}), 32'({1'b1, 3'b010}));
        step();
        chk("h0_idle", 32'({b_r, b_valid, b_id}), 32'({4'b0001, 1'b0, 3'b000}));
        step();
        chk("h0_g1", 32'({b_valid, b_id}), 32'({1'b1, 3'b001}));
        step();
        chk("h0_done", 32'({b_r, b_valid}), 32'({4'b0000, 1'b0}));

        // Random traffic against the model for both hold settings.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            for (int b = 1; b <= 4; b++) req_pulse[b] = ($urandom_range(0, 3) == 0);
            svc_ready = ($urandom_range(0, 1) == 1);
            ovf_clr   = ($urandom_range(0, 9) == 0);
            reset     = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
